// File: rtl/screen_msg_tx_if.sv
// Bus between the screen transmitter, its line-table ROM and the byte UART.
// The master side drives the table address and the UART byte/strobe;
// the slave side returns the table word and the UART busy flag.
interface screen_msg_tx_if #(
    parameter int LINE_BYTES = 16,
    parameter int NUM_LINES  = 8,
    localparam int LIW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
);
    logic [LIW-1:0]          line_idx;
    logic [8*LINE_BYTES-1:0] line_data;
    logic [7:0]              tx_data;
    logic                    tx_en;
    logic                    tx_busy;

    modport master (
        output line_idx,
        output tx_data,
        output tx_en,
        input  line_data,
        input  tx_busy
    );

    modport slave (
        input  line_idx,
        input  tx_data,
        input  tx_en,
        output line_data,
        output tx_busy
    );
endinterface

// File: rtl/screen_msg_tx.sv
// Screen message transmitter: walks a table of fixed-width text lines held
// in an external ROM and feeds each line, most significant byte first, into
// the byte UART. Leading NUL padding of right-justified lines can be
// suppressed. Supports a runtime line count, repeat mode and abort.
module screen_msg_tx #(
    parameter int LINE_BYTES = 16,
    parameter int NUM_LINES  = 8,
    parameter bit SKIP_NUL   = 1'b1,
    localparam int LIW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int CW  = $clog2(NUM_LINES + 1),
    localparam int BCW = $clog2(LINE_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  repeat_en,
    input  logic                  abort,
    input  logic [CW-1:0]         line_count,
    screen_msg_tx_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [15:0]           bytes_sent
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_SCAN    = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_WAIT_HI = 3'd5;
    localparam logic [2:0] S_WAIT_LO = 3'd6;
    localparam logic [2:0] S_NEXT    = 3'd7;

    localparam logic [CW-1:0]  MAX_CNT   = CW'(NUM_LINES);
    localparam logic [BCW-1:0] LINE_BCNT = BCW'(LINE_BYTES);

    logic [2:0]              state_q,    state_d;
    logic [LIW-1:0]          line_idx_q, line_idx_d;
    logic [CW-1:0]           count_q,    count_d;
    logic [8*LINE_BYTES-1:0] shift_q,    shift_d;
    logic [BCW-1:0]          bcnt_q,     bcnt_d;
    logic                    lead_q,     lead_d;
    logic                    pend_q,     pend_d;
    logic [7:0]              tx_data_q,  tx_data_d;
    logic                    tx_en_q,    tx_en_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;
    logic                    aborted_q,  aborted_d;
    logic [15:0]             bytes_q,    bytes_d;

    logic [CW-1:0] count_clamped;
    logic [7:0]    top_byte;
    logic [CW:0]   next_idx;

    assign count_clamped = (line_count > MAX_CNT) ? MAX_CNT : line_count;
    assign top_byte      = shift_q[8*LINE_BYTES-1 -: 8];
    assign next_idx      = {{(CW+1-LIW){1'b0}}, line_idx_q} + (CW+1)'(1);

    // Next-state logic: line walking, leading-NUL skipping and UART handshake
    always_comb begin
        state_d    = state_q;
        line_idx_d = line_idx_q;
        count_d    = count_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        lead_d     = lead_q;
        pend_d     = pend_q;
        tx_data_d  = tx_data_q;
        tx_en_d    = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        bytes_d    = bytes_q;

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (start) begin
                    if (count_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        count_d    = count_clamped;
                        line_idx_d = '0;
                        bytes_d    = '0;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    shift_d = bus.line_data;
                    bcnt_d  = LINE_BCNT;
                    lead_d  = SKIP_NUL;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort || pend_q) begin
                    aborted_d = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (lead_q && (top_byte == 8'h00)) begin
                    shift_d = shift_q << 8;
                    bcnt_d  = bcnt_q - BCW'(1);
                    if (bcnt_q == BCW'(1)) begin
                        state_d = S_NEXT;
                    end
                end else begin
                    lead_d  = 1'b0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    pend_d = 1'b1;
                end
                if (!bus.tx_busy) begin
                    tx_data_d = top_byte;
                    tx_en_d   = 1'b1;
                    if (bytes_q != 16'hFFFF) begin
                        bytes_d = bytes_q + 16'd1;
                    end
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (abort) begin
                    pend_d = 1'b1;
                end
                if (bus.tx_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (abort) begin
                    pend_d = 1'b1;
                end
                if (!bus.tx_busy) begin
                    shift_d = shift_q << 8;
                    bcnt_d  = bcnt_q - BCW'(1);
                    state_d = (bcnt_q == BCW'(1)) ? S_NEXT : S_SCAN;
                end
            end
            S_NEXT: begin
                if (abort || pend_q) begin
                    aborted_d = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (next_idx < {1'b0, count_q}) begin
                    line_idx_d = line_idx_q + LIW'(1);
                    state_d    = S_FETCH;
                end else if (repeat_en) begin
                    line_idx_d = '0;
                    state_d    = S_FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops the UART strobe at once
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            line_idx_q <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            bcnt_q     <= '0;
            lead_q     <= 1'b0;
            pend_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            bytes_q    <= '0;
        end else begin
            state_q    <= state_d;
            line_idx_q <= line_idx_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bcnt_q     <= bcnt_d;
            lead_q     <= lead_d;
            pend_q     <= pend_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            bytes_q    <= bytes_d;
        end
    end

    assign bus.line_idx = line_idx_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_en    = tx_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign bytes_sent   = bytes_q;

endmodule

// File: tb/tb_screen_msg_tx.sv
// Bench for screen_msg_tx: two instances (NUL skipping on and off) share the
// same 4-byte line table and control inputs, each with its own ROM and UART.
// The expected byte stream of one pass is derived from the table contents;
// a per-cycle checker compares strobed bytes and byte counts against it.
module tb_screen_msg_tx;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        repeatEn;
    logic        abortReq;
    logic [3:0]  lineCount;

    logic [1:0]  txEn;
    logic [1:0]  txBusy;
    logic [1:0]  busyW;
    logic [1:0]  doneW;
    logic [1:0]  abortedW;
    logic [7:0]  txData    [2];
    logic [2:0]  lineIdx   [2];
    logic [15:0] bytesSent [2];

    logic [31:0] rom [8];

    int compared;
    int mismatched;
    int strobes  [2];
    int doneCnt  [2];
    int abortCnt [2];
    logic [1:0] txEnPrev;
    logic [1:0] busyPrev;

    logic [7:0] pass0 [$];
    logic [7:0] pass1 [$];
    logic [7:0] log0  [$];
    logic [7:0] log1  [$];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : gInst
        screen_msg_tx_if #(.LINE_BYTES(4), .NUM_LINES(8)) bus ();
        logic [3:0] uartCnt;

        screen_msg_tx #(
            .LINE_BYTES(4),
            .NUM_LINES (8),
            .SKIP_NUL  (g == 0)
        ) dut (
            .clk       (clk),
            .resetn    (resetn),
            .start     (start),
            .repeat_en (repeatEn),
            .abort     (abortReq),
            .line_count(lineCount),
            .bus       (bus),
            .busy      (busyW[g]),
            .done      (doneW[g]),
            .aborted   (abortedW[g]),
            .bytes_sent(bytesSent[g])
        );

        // Table ROM with one cycle of read latency
        always_ff @(posedge clk) begin
            bus.line_data <= rom[bus.line_idx];
        end

        // UART stand-in: busy for ten cycles after each strobe
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                bus.tx_busy <= 1'b0;
                uartCnt     <= 4'd0;
            end else if (bus.tx_en && !bus.tx_busy) begin
                bus.tx_busy <= 1'b1;
                uartCnt     <= 4'd10;
            end else if (bus.tx_busy) begin
                uartCnt <= uartCnt - 4'd1;
                if (uartCnt == 4'd1) begin
                    bus.tx_busy <= 1'b0;
                end
            end
        end

        assign txEn[g]    = bus.tx_en;
        assign txData[g]  = bus.tx_data;
        assign txBusy[g]  = bus.tx_busy;
        assign lineIdx[g] = bus.line_idx;
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s[%0d] got %h want %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // One pass over the clamped line count; leading NULs dropped only for inst 0
    task automatic buildModel(input int cnt);
        int n;
        bit lead;
        logic [7:0] b;
        n = (cnt > 8) ? 8 : cnt;
        pass0.delete();
        pass1.delete();
        for (int l = 0; l < n; l++) begin
            lead = 1'b1;
            for (int k = 3; k >= 0; k--) begin
                b = rom[l][8*k +: 8];
                pass1.push_back(b);
                if (!(lead && b == 8'h00)) begin
                    lead = 1'b0;
                    pass0.push_back(b);
                end
            end
        end
    endtask

    function automatic int passLen(input int i);
        return (i == 0) ? pass0.size() : pass1.size();
    endfunction

    function automatic logic [7:0] expByte(input int i, input int k);
        if (i == 0) return pass0[k % pass0.size()];
        return pass1[k % pass1.size()];
    endfunction

    // Per-cycle check of both instances against the table-derived byte stream
    always @(negedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) strobes[i] = 0;
            txEnPrev = 2'b00;
            busyPrev = 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (busyW[i] && !busyPrev[i]) strobes[i] = 0;
                if (txEn[i]) begin
                    if (passLen(i) == 0) begin
                        checkOutput("unexpectedStrobe", i, 32'(txEn[i]), 32'd0);
                    end else begin
                        checkOutput("txData", i, 32'(txData[i]), 32'(expByte(i, strobes[i])));
                    end
                    checkOutput("txEnWidth", i, 32'(txEnPrev[i]), 32'd0);
                    strobes[i]++;
                    if (i == 0) log0.push_back(txData[i]);
                    else        log1.push_back(txData[i]);
                end
                checkOutput("bytesSent", i, 32'(bytesSent[i]),
                            (strobes[i] > 65535) ? 32'd65535 : 32'(strobes[i]));
                checkOutput("doneAbortExcl", i, 32'(doneW[i] & abortedW[i]), 32'd0);
                if (doneW[i]) begin
                    doneCnt[i]++;
                    checkOutput("busyAtDone", i, 32'(busyW[i]), 32'd0);
                    if (passLen(i) > 0) begin
                        checkOutput("wholePasses", i, 32'(strobes[i] % passLen(i)), 32'd0);
                    end
                end
                if (abortedW[i]) abortCnt[i]++;
            end
            txEnPrev = txEn;
            busyPrev = busyW;
        end
    end

    task automatic applyStimulus(input int cnt, input logic rpt);
        buildModel(cnt);
        log0.delete();
        log1.delete();
        for (int i = 0; i < 2; i++) begin
            doneCnt[i]  = 0;
            abortCnt[i] = 0;
        end
        lineCount = 4'(cnt);
        repeatEn  = rpt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while ((busyW != 2'b00) && (n < maxCycles)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleReached", 0, 32'(busyW), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        compared   = 0;
        mismatched = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        repeatEn   = 1'b0;
        abortReq   = 1'b0;
        lineCount  = 4'd0;
        for (int i = 0; i < 8; i++) rom[i] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            doneCnt[i]  = 0;
            abortCnt[i] = 0;
            strobes[i]  = 0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("rstLineIdx", i, 32'(lineIdx[i]), 32'd0);
            checkOutput("rstTxData", i, 32'(txData[i]), 32'd0);
            checkOutput("rstTxEn", i, 32'(txEn[i]), 32'd0);
            checkOutput("rstBusy", i, 32'(busyW[i]), 32'd0);
            checkOutput("rstDone", i, 32'(doneW[i]), 32'd0);
            checkOutput("rstAborted", i, 32'(abortedW[i]), 32'd0);
            checkOutput("rstBytes", i, 32'(bytesSent[i]), 32'd0);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Two lines, leading NULs on line 0
        rom[0] = 32'h0000_000C;
        rom[1] = 32'h0A0D_4142;
        applyStimulus(2, 1'b0);
        waitIdle(2000);
        checkOutput("t1Len", 0, 32'(log0.size()), 32'd5);
        checkOutput("t1First", 0, 32'(log0[0]), 32'h0C);
        checkOutput("t1Mid", 0, 32'(log0[2]), 32'h0D);
        checkOutput("t1Last", 0, 32'(log0[4]), 32'h42);
        checkOutput("t1Bytes", 0, 32'(bytesSent[0]), 32'd5);
        checkOutput("t1Done", 0, 32'(doneCnt[0]), 32'd1);
        checkOutput("t1Len", 1, 32'(log1.size()), 32'd8);
        checkOutput("t1Pad", 1, 32'(log1[2]), 32'h00);
        checkOutput("t1Fourth", 1, 32'(log1[3]), 32'h0C);
        checkOutput("t1Bytes", 1, 32'(bytesSent[1]), 32'd8);

        // Interior zero byte is sent once the line has started
        rom[0] = 32'h0041_0042;
        applyStimulus(1, 1'b0);
        waitIdle(2000);
        checkOutput("t2Len", 0, 32'(log0.size()), 32'd3);
        checkOutput("t2B0", 0, 32'(log0[0]), 32'h41);
        checkOutput("t2B1", 0, 32'(log0[1]), 32'h00);
        checkOutput("t2B2", 0, 32'(log0[2]), 32'h42);
        checkOutput("t2Len", 1, 32'(log1.size()), 32'd4);

        // Zero line count: done on the next cycle, nothing sent
        buildModel(0);
        log0.delete();
        log1.delete();
        lineCount = 4'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t3ZeroDone", 0, 32'(doneW[0]), 32'd1);
        checkOutput("t3ZeroDone", 1, 32'(doneW[1]), 32'd1);
        checkOutput("t3ZeroBusy", 0, 32'(busyW[0]), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t3ZeroNoTx", 0, 32'(log0.size()), 32'd0);

        // Line count above the table depth is clamped
        for (int i = 0; i < 8; i++) rom[i] = 32'h30 + 32'(i);
        applyStimulus(15, 1'b0);
        waitIdle(8000);
        checkOutput("t3ClampLen", 0, 32'(log0.size()), 32'd8);
        checkOutput("t3ClampLast", 0, 32'(log0[7]), 32'h37);
        checkOutput("t3ClampBytes", 0, 32'(bytesSent[0]), 32'd8);
        checkOutput("t3ClampLen", 1, 32'(log1.size()), 32'd32);

        // Repeat mode, then drop repeat to finish the current pass
        rom[0] = 32'h0000_0031;
        applyStimulus(1, 1'b1);
        n = 0;
        while ((log0.size() < 3) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        repeatEn = 1'b0;
        waitIdle(2000);
        checkOutput("t4Repeats", 0, 32'(log0.size() >= 3), 32'd1);
        checkOutput("t4Byte", 0, 32'(log0[2]), 32'h31);
        checkOutput("t4Done", 0, 32'(doneCnt[0]), 32'd1);
        checkOutput("t4Done", 1, 32'(doneCnt[1]), 32'd1);

        // Abort while the second byte is in flight
        rom[0] = 32'h4142_4344;
        applyStimulus(1, 1'b0);
        n = 0;
        while ((log0.size() < 2) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checkOutput("t5UartBusy", 0, 32'(txBusy[0]), 32'd1);
        abortReq = 1'b1;
        @(negedge clk);
        abortReq = 1'b0;
        waitIdle(2000);
        repeat (20) @(negedge clk);
        checkOutput("t5Len", 0, 32'(log0.size()), 32'd2);
        checkOutput("t5Bytes", 0, 32'(bytesSent[0]), 32'd2);
        checkOutput("t5Aborted", 0, 32'(abortCnt[0]), 32'd1);
        checkOutput("t5NoDone", 0, 32'(doneCnt[0]), 32'd0);
        checkOutput("t5Busy", 0, 32'(busyW[0]), 32'd0);

        // Abort while scanning an all-NUL line
        rom[0] = 32'h0000_0000;
        applyStimulus(1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abortReq = 1'b1;
        @(negedge clk);
        abortReq = 1'b0;
        checkOutput("t5ScanAborted", 0, 32'(abortedW[0]), 32'd1);
        checkOutput("t5ScanAborted", 1, 32'(abortedW[1]), 32'd1);
        checkOutput("t5ScanBusy", 0, 32'(busyW[0]), 32'd0);
        waitIdle(100);

        // Reset in the middle of a byte, then a clean run from line 0
        rom[0] = 32'h4142_4344;
        applyStimulus(1, 1'b0);
        n = 0;
        while (!txEn[0] && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6Strobe", 0, 32'(txEn[0]), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("t6RstTxEn", 0, 32'(txEn[0]), 32'd0);
        checkOutput("t6RstBusy", 0, 32'(busyW[0]), 32'd0);
        checkOutput("t6RstBytes", 0, 32'(bytesSent[0]), 32'd0);
        checkOutput("t6RstTxData", 0, 32'(txData[0]), 32'd0);
        checkOutput("t6RstLineIdx", 0, 32'(lineIdx[0]), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        rom[0] = 32'h0000_000C;
        rom[1] = 32'h0A0D_4142;
        applyStimulus(2, 1'b0);
        waitIdle(2000);
        checkOutput("t6Len", 0, 32'(log0.size()), 32'd5);
        checkOutput("t6First", 0, 32'(log0[0]), 32'h0C);
        checkOutput("t6Done", 0, 32'(doneCnt[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
